// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
//  Shared constants for the 7-segment encoder/decoder pair.
//  Segment byte layout is {a,b,c,d,e,f,g,dp}: bit 7 = a ... bit 1 = g, bit 0 = dp.
//  Contents:
//   SEG_ZERO..SEG_NINE  segment patterns for decimal digits 0..9
//   SEG_ERR             encoder marker for an out-of-range value (dp only)
//   DEC_MARK            decoded value reported for SEG_ERR
//   DEC_BAD             decoded value reported for any unrecognised pattern
//   dec_state_t         frame assembly FSM states
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [7:0] SEG_ZERO  = 8'b1111_1100;
    localparam logic [7:0] SEG_ONE   = 8'b0110_0000;
    localparam logic [7:0] SEG_TWO   = 8'b1101_1010;
    localparam logic [7:0] SEG_THREE = 8'b1111_0010;
    localparam logic [7:0] SEG_FOUR  = 8'b0110_0110;
    localparam logic [7:0] SEG_FIVE  = 8'b1011_0110;
    localparam logic [7:0] SEG_SIX   = 8'b1011_1110;
    localparam logic [7:0] SEG_SEVEN = 8'b1110_0000;
    localparam logic [7:0] SEG_EIGHT = 8'b1111_1110;
    localparam logic [7:0] SEG_NINE  = 8'b1111_0110;

    // The encoder lights only the decimal point when its input is out of range.
    localparam logic [7:0] SEG_ERR   = 8'b0000_0001;

    localparam logic [3:0] DEC_MARK  = 4'hF;
    localparam logic [3:0] DEC_BAD   = 4'hE;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        COLLECT   = 2'd1,
        PUBLISH   = 2'd2
    } dec_state_t;

endpackage

// File: rtl/seg_to_bin.sv
// ----------------------------------------------------------------------------
// seg_to_bin
//  Purely combinational 7-segment pattern -> BCD decoder. Only exact matches of
//  the ten digit patterns decode cleanly; the encoder's out-of-range marker maps
//  to DEC_MARK and everything else (including any digit with dp lit, or a dark
//  display) maps to DEC_BAD. Both error cases raise err.
//  Ports:
//   seg    in  8  segment pattern {a,b,c,d,e,f,g,dp}
//   value  out 4  decoded digit, DEC_MARK or DEC_BAD
//   err    out 1  pattern is not a clean decimal digit
// ----------------------------------------------------------------------------
module seg_to_bin
    import seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] value,
    output logic       err
);

    // Exact-match lookup of the segment pattern.
    always_comb begin
        value = DEC_BAD;
        err   = 1'b1;
        case (seg)
            SEG_ZERO:  begin value = 4'd0;     err = 1'b0; end
            SEG_ONE:   begin value = 4'd1;     err = 1'b0; end
            SEG_TWO:   begin value = 4'd2;     err = 1'b0; end
            SEG_THREE: begin value = 4'd3;     err = 1'b0; end
            SEG_FOUR:  begin value = 4'd4;     err = 1'b0; end
            SEG_FIVE:  begin value = 4'd5;     err = 1'b0; end
            SEG_SIX:   begin value = 4'd6;     err = 1'b0; end
            SEG_SEVEN: begin value = 4'd7;     err = 1'b0; end
            SEG_EIGHT: begin value = 4'd8;     err = 1'b0; end
            SEG_NINE:  begin value = 4'd9;     err = 1'b0; end
            SEG_ERR:   begin value = DEC_MARK; err = 1'b1; end
            default:   begin value = DEC_BAD;  err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_frame_decoder.sv
// ----------------------------------------------------------------------------
// seg_frame_decoder
//  Snoops a time-multiplexed 7-segment bus, debounces each digit dwell, decodes
//  it back to BCD and publishes a complete frame of NUMDIGITS digits with a
//  one-cycle valid strobe.
//  Parameters:
//   NUMDIGITS      digits per frame (width of an)
//   STABLE_CYCLES  consecutive identical (seg,an) cycles needed to accept a digit
//  Ports:
//   clk          in   1            rising-edge clock
//   rst          in   1            synchronous active-high reset
//   seg          in   8            {a,b,c,d,e,f,g,dp}
//   an           in   NUMDIGITS    active-high one-hot digit enable, an[0] = LS digit
//   digits       out  4*NUMDIGITS  published frame, digit i in [4i+3:4i]
//   digit_err    out  NUMDIGITS    per-digit decode error of the published frame
//   frame_err    out  1            OR of digit_err
//   frame_valid  out  1            pulses for one cycle when the outputs update
// ----------------------------------------------------------------------------
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int NUMDIGITS     = 4,
    parameter int STABLE_CYCLES = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             seg,
    input  logic [NUMDIGITS-1:0]   an,
    output logic [4*NUMDIGITS-1:0] digits,
    output logic [NUMDIGITS-1:0]   digit_err,
    output logic                   frame_err,
    output logic                   frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    localparam logic [CW-1:0]          CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0]          CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]          CNT_STABLE = CW'(STABLE_CYCLES);
    localparam logic [NUMDIGITS-1:0]   AN_ZERO    = NUMDIGITS'(0);
    localparam logic [NUMDIGITS-1:0]   AN_ONE     = NUMDIGITS'(1);
    localparam logic [NUMDIGITS-1:0]   SEEN_ALL   = {NUMDIGITS{1'b1}};
    localparam logic [4*NUMDIGITS-1:0] DIG_ZERO   = {(4*NUMDIGITS){1'b0}};

    // True when exactly one digit enable is active.
    function automatic logic an_onehot(input logic [NUMDIGITS-1:0] v);
        return (v != AN_ZERO) && ((v & (v - AN_ONE)) == AN_ZERO);
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [7:0]             prev_seg_r;
    logic [NUMDIGITS-1:0]   prev_an_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_next_s;
    logic                   onehot_s;
    logic                   match_s;
    logic                   capture_s;

    logic [3:0]             dec_val_s;
    logic                   dec_err_s;

    dec_state_t             state_r;
    dec_state_t             next_state_s;
    logic                   store_s;
    logic                   publish_s;
    logic [NUMDIGITS-1:0]   seen_r;
    logic [NUMDIGITS-1:0]   seen_next_s;
    logic [4*NUMDIGITS-1:0] shadow_r;
    logic [NUMDIGITS-1:0]   shadow_err_r;

    // ------------------------------------------------------------------
    // Pattern decoder
    // ------------------------------------------------------------------
    seg_to_bin u_seg_to_bin (
        .seg   (seg),
        .value (dec_val_s),
        .err   (dec_err_s)
    );

    // ------------------------------------------------------------------
    // Dwell stability tracking
    // ------------------------------------------------------------------

    // Run-length of the current (seg,an) dwell and the one-shot capture strobe.
    always_comb begin
        cnt_next_s = CNT_ZERO;
        capture_s  = 1'b0;
        onehot_s   = an_onehot(an);
        match_s    = (seg == prev_seg_r) && (an == prev_an_r);
        if (!onehot_s) begin
            // Blanking or overlapping enables never belong to a dwell.
            cnt_next_s = CNT_ZERO;
        end else if (match_s) begin
            if (cnt_r == CNT_STABLE) begin
                cnt_next_s = CNT_STABLE;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = CNT_ONE;
        end
        // A counter already saturated on the same dwell has fired before,
        // so a long dwell is captured only once.
        if (onehot_s && (cnt_next_s == CNT_STABLE) && !(match_s && (cnt_r == CNT_STABLE))) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Previous-cycle bus snapshot and dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_seg_r <= 8'h00;
            prev_an_r  <= AN_ZERO;
            cnt_r      <= CNT_ZERO;
        end else begin
            prev_seg_r <= seg;
            prev_an_r  <= an;
            cnt_r      <= cnt_next_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly FSM
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_SYNC;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            WAIT_SYNC: begin
                if (store_s) begin
                    next_state_s = COLLECT;
                end else begin
                    next_state_s = WAIT_SYNC;
                end
            end
            COLLECT: begin
                if (seen_next_s == SEEN_ALL) begin
                    next_state_s = PUBLISH;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            PUBLISH: begin
                next_state_s = COLLECT;
            end
            default: begin
                next_state_s = WAIT_SYNC;
            end
        endcase
    end

    // FSM outputs: which captures are kept, the next seen mask, publish request.
    always_comb begin
        store_s     = 1'b0;
        seen_next_s = seen_r;
        publish_s   = 1'b0;
        case (state_r)
            WAIT_SYNC: begin
                // Alignment point of a frame is the least significant digit.
                if (capture_s && an[0]) begin
                    store_s     = 1'b1;
                    seen_next_s = AN_ONE;
                end else begin
                    store_s     = 1'b0;
                    seen_next_s = AN_ZERO;
                end
            end
            COLLECT: begin
                if (capture_s) begin
                    store_s     = 1'b1;
                    seen_next_s = seen_r | an;
                end else begin
                    store_s     = 1'b0;
                    seen_next_s = seen_r;
                end
            end
            PUBLISH: begin
                publish_s = 1'b1;
                // A capture landing here already belongs to the next frame.
                if (capture_s) begin
                    store_s     = 1'b1;
                    seen_next_s = an;
                end else begin
                    store_s     = 1'b0;
                    seen_next_s = AN_ZERO;
                end
            end
            default: begin
                store_s     = 1'b0;
                seen_next_s = AN_ZERO;
                publish_s   = 1'b0;
            end
        endcase
    end

    // Seen mask, shadow frame and the published output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_r       <= AN_ZERO;
            shadow_r     <= DIG_ZERO;
            shadow_err_r <= AN_ZERO;
            digits       <= DIG_ZERO;
            digit_err    <= AN_ZERO;
            frame_err    <= 1'b0;
            frame_valid  <= 1'b0;
        end else begin
            seen_r <= seen_next_s;
            // an is one-hot whenever store_s is set, so it doubles as the
            // write select; a recapture simply overwrites the older value.
            for (int i = 0; i < NUMDIGITS; i++) begin
                if (store_s && an[i]) begin
                    shadow_r[4*i +: 4] <= dec_val_s;
                    shadow_err_r[i]    <= dec_err_s;
                end
            end
            frame_valid <= publish_s;
            if (publish_s) begin
                digits    <= shadow_r;
                digit_err <= shadow_err_r;
                frame_err <= |shadow_err_r;
            end
        end
    end

endmodule

// File: tb/tb_seg_frame_decoder.sv
module tb_seg_frame_decoder;

    localparam int ND = 4;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    seg;
    logic [ND-1:0] an;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_err;
    logic          frame_err;
    logic          frame_valid;

    seg_frame_decoder #(.NUMDIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .digit_err   (digit_err),
        .frame_err   (frame_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    // Display truth table, written out independently of the design package.
    logic [7:0] pat [10] = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110,
                             8'b10110110, 8'b10111110, 8'b11100000, 8'b11111110, 8'b11110110};

    typedef struct {
        int              cyc;
        logic [4*ND-1:0] d;
        logic [ND-1:0]   e;
    } frame_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulses  = 0;
    int p0;

    // Reference model state: dwell run, sync flag, digits gathered this frame.
    logic [ND-1:0]   run_an;
    logic [7:0]      run_seg;
    int              run_len;
    bit              synced;
    logic [ND-1:0]   m_seen;
    logic [3:0]      m_val [ND];
    logic            m_err [ND];
    frame_t          exp_q [$];
    logic [4*ND-1:0] last_d;
    logic [ND-1:0]   last_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void ref_decode(input logic [7:0] p, output logic [3:0] v, output logic e);
        v = 4'hE;
        e = 1'b1;
        if (p == 8'h01) v = 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (p == pat[k]) begin
                v = 4'(k);
                e = 1'b0;
            end
        end
    endfunction

    // One bus cycle seen from the specification's point of view.
    task automatic model_cycle(input logic [ND-1:0] a, input logic [7:0] s);
        int idx;
        logic [3:0] v;
        logic e;
        frame_t f;
        if ($countones(a) == 1) begin
            if (a == run_an && s == run_seg) run_len++;
            else run_len = 1;
        end else begin
            run_len = 0;
        end
        run_an  = a;
        run_seg = s;
        if (run_len == SC) begin
            idx = 0;
            for (int k = 0; k < ND; k++) if (a[k]) idx = k;
            ref_decode(s, v, e);
            if (synced || idx == 0) begin
                synced      = 1'b1;
                m_val[idx]  = v;
                m_err[idx]  = e;
                m_seen[idx] = 1'b1;
                if (m_seen == {ND{1'b1}}) begin
                    for (int k = 0; k < ND; k++) begin
                        f.d[4*k +: 4] = m_val[k];
                        f.e[k]        = m_err[k];
                    end
                    f.cyc = cyc + 2;
                    exp_q.push_back(f);
                    m_seen = '0;
                end
            end
        end
    endtask

    task automatic step(input logic [ND-1:0] a, input logic [7:0] s);
        @(posedge clk);
        #1;
        rst = 1'b0;
        an  = a;
        seg = s;
        cyc++;
        model_cycle(a, s);
        @(negedge clk);
        if (frame_valid === 1'b1) pulses++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            last_d = exp_q[0].d;
            last_e = exp_q[0].e;
            void'(exp_q.pop_front());
            chk("frame_valid pulse", 32'(frame_valid), 32'(1));
            chk("digits", 32'(digits), 32'(last_d));
            chk("digit_err", 32'(digit_err), 32'(last_e));
            chk("frame_err", 32'(frame_err), 32'(|last_e));
        end else begin
            chk("frame_valid idle", 32'(frame_valid), 32'(0));
            chk("digits hold", 32'(digits), 32'(last_d));
            chk("digit_err hold", 32'(digit_err), 32'(last_e));
        end
    endtask

    task automatic dwell(input logic [ND-1:0] a, input logic [7:0] s, input int len);
        for (int k = 0; k < len; k++) step(a, s);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        an  = '0;
        seg = 8'h00;
        cyc++;
        run_an  = '0;
        run_seg = 8'h00;
        run_len = 0;
        synced  = 1'b0;
        m_seen  = '0;
        exp_q.delete();
        last_d  = '0;
        last_e  = '0;
    endtask

    // Full sweep an[0]..an[ND-1] with the given segment bytes.
    task automatic sweep(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] s3, input int len);
        dwell(4'b0001, s0, len);
        dwell(4'b0010, s1, len);
        dwell(4'b0100, s2, len);
        dwell(4'b1000, s3, len);
    endtask

    initial begin
        logic [ND-1:0] a;
        logic [7:0]    s;
        int            r;

        rst = 1'b1;
        an  = '0;
        seg = 8'h00;
        repeat (2) @(posedge clk);
        do_reset();
        step(4'b0000, 8'h00);
        chk("reset digits", 32'(digits), 32'h0);
        chk("reset digit_err", 32'(digit_err), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset frame_valid", 32'(frame_valid), 32'h0);

        // Basic sweep, two cycles per digit.
        p0 = pulses;
        sweep(pat[1], pat[2], pat[3], pat[4], 2);
        dwell(4'b0000, 8'h00, 3);
        chk("t1 pulse count", 32'(pulses - p0), 32'd1);
        chk("t1 digits", 32'(digits), 32'h4321);
        chk("t1 frame_err", 32'(frame_err), 32'h0);

        // Dwells shorter than the stability window are never captured.
        p0 = pulses;
        sweep(pat[5], pat[6], pat[7], pat[8], 1);
        dwell(4'b0000, 8'h00, 3);
        chk("t2 pulse count", 32'(pulses - p0), 32'd0);
        chk("t2 digits kept", 32'(digits), 32'h4321);

        // Sweep starting mid-frame after reset is discarded until digit 0.
        do_reset();
        p0 = pulses;
        dwell(4'b0100, pat[3], 2);
        dwell(4'b1000, pat[4], 2);
        dwell(4'b0000, 8'h00, 2);
        chk("t3 no early frame", 32'(pulses - p0), 32'd0);
        sweep(pat[5], pat[6], pat[7], pat[8], 2);
        dwell(4'b0000, 8'h00, 3);
        chk("t3 pulse count", 32'(pulses - p0), 32'd1);
        chk("t3 digits", 32'(digits), 32'h8765);

        // Error patterns: encoder marker and all segments lit.
        sweep(pat[9], pat[0], 8'h01, 8'hFF, 2);
        dwell(4'b0000, 8'h00, 3);
        chk("t4 digits", 32'(digits), 32'hEF09);
        chk("t4 digit_err", 32'(digit_err), 32'hC);
        chk("t4 frame_err", 32'(frame_err), 32'h1);

        // Overlapping enables and blanking are ignored; a long dwell counts once.
        p0 = pulses;
        dwell(4'b0001, pat[1], 2);
        dwell(4'b0011, pat[8], 2);
        dwell(4'b0010, pat[2], 10);
        dwell(4'b0000, 8'h00, 3);
        dwell(4'b0100, pat[3], 2);
        dwell(4'b1000, pat[4], 2);
        dwell(4'b0000, 8'h00, 3);
        chk("t5 pulse count", 32'(pulses - p0), 32'd1);
        chk("t5 digits", 32'(digits), 32'h4321);
        chk("t5 frame_err", 32'(frame_err), 32'h0);

        // Reset after three captures discards the partial frame.
        dwell(4'b0001, pat[9], 2);
        dwell(4'b0010, pat[9], 2);
        dwell(4'b0100, pat[9], 2);
        do_reset();
        p0 = pulses;
        dwell(4'b1000, pat[9], 2);
        sweep(pat[5], pat[6], pat[7], pat[8], 2);
        dwell(4'b0000, 8'h00, 3);
        chk("t6 pulse count", 32'(pulses - p0), 32'd1);
        chk("t6 digits", 32'(digits), 32'h8765);

        // Back-to-back sweeps: one pulse per sweep.
        p0 = pulses;
        for (int k = 0; k < 5; k++) begin
            sweep(pat[$urandom_range(0, 9)], pat[$urandom_range(0, 9)],
                  pat[$urandom_range(0, 9)], pat[$urandom_range(0, 9)], 2);
        end
        dwell(4'b0000, 8'h00, 3);
        chk("t6 continuous pulses", 32'(pulses - p0), 32'd5);

        // Random dwells against the reference model.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else begin
                if (r < 75) a = 4'b0001 << $urandom_range(0, ND - 1);
                else if (r < 88) a = 4'b0000;
                else a = 4'($urandom);
                r = $urandom_range(0, 9);
                if (r < 8) s = pat[$urandom_range(0, 9)];
                else if (r == 8) s = 8'h01;
                else s = 8'($urandom);
                dwell(a, s, $urandom_range(1, 4));
            end
        end
        dwell(4'b0000, 8'h00, 4);
        chk("drain expected frames", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
